// File: rtl/vc_out_arbiter_if.sv
// Bus bundle between the per-VC input buffers, the output VC scheduler and the link.
// The master modport is the environment side. The slave modport is the scheduler side.
interface vc_out_arbiter_if #(
    parameter int N_VC   = 4,
    parameter int FLIT_W = 34
);
    logic [N_VC*FLIT_W-1:0] vc_fdata_i;
    logic [N_VC-1:0]        vc_valid_i;
    logic [N_VC-1:0]        vc_ready_o;
    logic [FLIT_W-1:0]      fdata_o;
    logic [1:0]             vc_id_o;
    logic                   valid_o;
    logic                   ready_i;
    logic [N_VC-1:0]        credit_i;
    logic                   err_o;

    modport master (
        output vc_fdata_i, vc_valid_i, ready_i, credit_i,
        input  vc_ready_o, fdata_o, vc_id_o, valid_o, err_o
    );

    modport slave (
        input  vc_fdata_i, vc_valid_i, ready_i, credit_i,
        output vc_ready_o, fdata_o, vc_id_o, valid_o, err_o
    );
endinterface

// File: rtl/vc_out_arbiter.sv
// Output-port VC scheduler. It uses round-robin grant, holds a wormhole lock while a
// multi-flit packet is in flight, and keeps per-VC downstream credit counters.
module vc_out_arbiter #(
    parameter int N_VC     = 4,
    parameter int FLIT_W   = 34,
    parameter int SIZE_LSB = 22,
    parameter int SIZE_MSB = 29,
    parameter int CREDITS  = 2
) (
    input  logic            clk,
    input  logic            arst,
    vc_out_arbiter_if.slave bus
);
    localparam int CW = $clog2(CREDITS + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [1:0] FT_HEAD = 2'b00;
    localparam logic [1:0] FT_TAIL = 2'b11;

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [1:0]        rr_ptr_q;
    logic [1:0]        rr_ptr_d;
    logic [1:0]        lock_vc_q;
    logic [1:0]        lock_vc_d;
    logic [CW-1:0]     credit_q [N_VC];
    logic [CW-1:0]     credit_d [N_VC];
    logic              err_q;
    logic              err_d;

    logic [FLIT_W-1:0] flit_s [N_VC];
    logic [N_VC-1:0]   eligible_s;
    logic              grant_vld_s;
    logic [1:0]        grant_s;
    logic [FLIT_W-1:0] sel_flit_s;
    logic [1:0]        sel_type_s;
    logic              size_nz_s;
    logic              hs_s;
    logic [N_VC-1:0]   pop_s;
    logic              valid_s;
    logic [FLIT_W-1:0] fdata_s;
    logic [1:0]        vc_id_s;
    logic              head_err_s;
    logic              sat_err_s;

    // VC index reached by stepping 'step' places past 'base', wrapping at N_VC.
    function automatic logic [1:0] wrap_idx(input logic [1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        return 2'(sum % N_VC);
    endfunction

    for (genvar gi = 0; gi < N_VC; gi++) begin : g_vc
        assign flit_s[gi]     = bus.vc_fdata_i[gi*FLIT_W +: FLIT_W];
        assign eligible_s[gi] = bus.vc_valid_i[gi] && (credit_q[gi] != {CW{1'b0}});
    end

    // Grant selection. When locked, only the owner VC can win.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = 2'b00;
        case (state_q)
            ST_IDLE: begin
                // Walk the scan order backwards so the first eligible VC is written last.
                for (int k = N_VC; k >= 1; k--) begin
                    if (eligible_s[wrap_idx(rr_ptr_q, k)]) begin
                        grant_vld_s = 1'b1;
                        grant_s     = wrap_idx(rr_ptr_q, k);
                    end else begin
                        grant_vld_s = grant_vld_s;
                    end
                end
            end
            ST_LOCKED: begin
                if (eligible_s[lock_vc_q]) begin
                    grant_vld_s = 1'b1;
                    grant_s     = lock_vc_q;
                end else begin
                    grant_vld_s = 1'b0;
                end
            end
            default: begin
                grant_vld_s = 1'b0;
                grant_s     = 2'b00;
            end
        endcase
    end

    // Forward path and pop. Everything is held at zero while reset is asserted.
    always_comb begin
        sel_flit_s = flit_s[grant_s];
        sel_type_s = sel_flit_s[FLIT_W-1 -: 2];
        size_nz_s  = |sel_flit_s[SIZE_MSB:SIZE_LSB];
        valid_s    = 1'b0;
        fdata_s    = {FLIT_W{1'b0}};
        vc_id_s    = 2'b00;
        pop_s      = {N_VC{1'b0}};
        hs_s       = 1'b0;
        if (arst && grant_vld_s) begin
            valid_s = 1'b1;
            fdata_s = sel_flit_s;
            vc_id_s = grant_s;
            if (bus.ready_i) begin
                hs_s           = 1'b1;
                pop_s[grant_s] = 1'b1;
            end else begin
                hs_s = 1'b0;
            end
        end else begin
            valid_s = 1'b0;
        end
    end

    // Scheduler state: the round-robin pointer moves only on a handshake.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_vc_d  = lock_vc_q;
        head_err_s = 1'b0;
        if (hs_s) begin
            case (state_q)
                ST_IDLE: begin
                    rr_ptr_d = grant_s;
                    if ((sel_type_s == FT_HEAD) && size_nz_s) begin
                        state_d   = ST_LOCKED;
                        lock_vc_d = grant_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (sel_type_s == FT_TAIL) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = lock_vc_q;
                    end else if (sel_type_s == FT_HEAD) begin
                        // The stray head is still forwarded. The packet keeps its lock.
                        head_err_s = 1'b1;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Credit counters. A pop and a returned credit in the same cycle cancel out.
    always_comb begin
        sat_err_s = 1'b0;
        for (int i = 0; i < N_VC; i++) begin
            credit_d[i] = credit_q[i];
            if (pop_s[i] && !bus.credit_i[i]) begin
                credit_d[i] = credit_q[i] - CW'(1);
            end else if (bus.credit_i[i] && !pop_s[i]) begin
                if (credit_q[i] == CW'(CREDITS)) begin
                    sat_err_s = 1'b1;
                end else begin
                    credit_d[i] = credit_q[i] + CW'(1);
                end
            end else begin
                credit_d[i] = credit_q[i];
            end
        end
        err_d = head_err_s | sat_err_s;
    end

    // State registers. Reset makes VC0 the first candidate and fills every credit.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= 2'(N_VC - 1);
            lock_vc_q <= 2'b00;
            err_q     <= 1'b0;
            for (int i = 0; i < N_VC; i++) begin
                credit_q[i] <= CW'(CREDITS);
            end
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_vc_q <= lock_vc_d;
            err_q     <= err_d;
            for (int i = 0; i < N_VC; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

    assign bus.valid_o    = valid_s;
    assign bus.fdata_o    = fdata_s;
    assign bus.vc_id_o    = vc_id_s;
    assign bus.vc_ready_o = pop_s;
    assign bus.err_o      = err_q;
endmodule

// File: tb/tb_vc_out_arbiter.sv
// Directed bench for vc_out_arbiter. A per-cycle behavioural model checks every output,
// and literal expectations pin the key scenarios.
module tb_vc_out_arbiter;
    localparam int N_VC    = 4;
    localparam int FLIT_W  = 34;
    localparam int CREDITS = 2;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    vc_out_arbiter_if #(.N_VC(N_VC), .FLIT_W(FLIT_W)) bus ();

    vc_out_arbiter #(.N_VC(N_VC), .FLIT_W(FLIT_W), .SIZE_LSB(22), .SIZE_MSB(29), .CREDITS(CREDITS))
        dut (.clk(clk), .arst(arst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    logic [FLIT_W-1:0] nxt_flit [N_VC];
    logic              nxt_arst;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [7:0] sz,
                                             input logic [21:0] pl);
        return {t, 2'b00, sz, pl};
    endfunction

    // Inputs change just after the rising edge. Outputs are read at the falling edge.
    task automatic drive(input logic [3:0] v, input logic r, input logic [3:0] c);
        @(posedge clk);
        #1;
        arst = nxt_arst;
        for (int i = 0; i < N_VC; i++) bus.vc_fdata_i[i*FLIT_W +: FLIT_W] = nxt_flit[i];
        bus.vc_valid_i = v;
        bus.ready_i    = r;
        bus.credit_i   = c;
        @(negedge clk);
    endtask

    // Reference model: scheduler rules in plain integers.
    bit m_locked;
    int m_lock;
    int m_rr;
    int m_cred [N_VC];
    bit m_err;

    always @(negedge clk) begin : model
        int g;
        int idx;
        bit hs;
        bit nerr;
        bit inc;
        bit dec;
        logic [FLIT_W-1:0] f;
        logic [FLIT_W-1:0] exp_data;
        logic [3:0] exp_ready;
        if (!arst) begin
            m_locked = 1'b0;
            m_lock   = 0;
            m_rr     = N_VC - 1;
            m_err    = 1'b0;
            for (int i = 0; i < N_VC; i++) m_cred[i] = CREDITS;
            chk("model_rst_outs", {bus.valid_o, bus.vc_ready_o, bus.vc_id_o, bus.fdata_o}, 64'd0);
            chk("model_rst_err", bus.err_o, 64'd0);
        end else begin
            g = -1;
            if (m_locked) begin
                if (bus.vc_valid_i[m_lock] && m_cred[m_lock] > 0) g = m_lock;
            end else begin
                for (int k = 1; k <= N_VC; k++) begin
                    idx = (m_rr + k) % N_VC;
                    if (g < 0 && bus.vc_valid_i[idx] && m_cred[idx] > 0) g = idx;
                end
            end
            f         = (g >= 0) ? bus.vc_fdata_i[g*FLIT_W +: FLIT_W] : '0;
            exp_data  = (g >= 0) ? f : '0;
            hs        = (g >= 0) && bus.ready_i;
            exp_ready = hs ? (4'b0001 << g) : 4'b0000;
            chk("model_valid", bus.valid_o, (g >= 0) ? 64'd1 : 64'd0);
            chk("model_fdata", bus.fdata_o, exp_data);
            chk("model_vc_id", bus.vc_id_o, (g >= 0) ? 64'(g) : 64'd0);
            chk("model_vc_ready", bus.vc_ready_o, exp_ready);
            chk("model_err", bus.err_o, m_err);
            nerr = 1'b0;
            if (hs) begin
                if (!m_locked) begin
                    m_rr = g;
                    if (f[33:32] == 2'b00 && f[29:22] != 8'd0) begin
                        m_locked = 1'b1;
                        m_lock   = g;
                    end
                end else if (f[33:32] == 2'b11) begin
                    m_locked = 1'b0;
                    m_rr     = m_lock;
                end else if (f[33:32] == 2'b00) begin
                    nerr = 1'b1;
                end
            end
            for (int i = 0; i < N_VC; i++) begin
                inc = bus.credit_i[i];
                dec = hs && (g == i);
                if (dec && !inc) m_cred[i]--;
                else if (inc && !dec) begin
                    if (m_cred[i] == CREDITS) nerr = 1'b1;
                    else m_cred[i]++;
                end
            end
            m_err = nerr;
        end
    end

    initial begin
        int ids [5];
        arst = 1'b0;
        nxt_arst = 1'b0;
        bus.vc_valid_i = '0;
        bus.ready_i    = 1'b0;
        bus.credit_i   = '0;
        bus.vc_fdata_i = '0;
        for (int i = 0; i < N_VC; i++) nxt_flit[i] = '0;
        drive(4'h0, 1'b0, 4'h0);
        drive(4'hF, 1'b1, 4'h0);
        chk("reset_valid", bus.valid_o, 64'd0);
        chk("reset_ready", bus.vc_ready_o, 64'd0);

        // Reset release: rotation over four single-flit heads.
        nxt_arst = 1'b1;
        for (int i = 0; i < N_VC; i++) nxt_flit[i] = mk(2'b00, 8'd0, 22'(i + 1));
        ids = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            drive(4'hF, 1'b1, 4'h0);
            chk("rr_id", bus.vc_id_o, 64'(ids[k]));
            chk("rr_ready", bus.vc_ready_o, 64'(4'b0001 << ids[k]));
        end
        drive(4'h0, 1'b1, 4'hF);
        drive(4'h0, 1'b1, 4'h1);

        // Wormhole lock on VC1 while VC0 waits.
        nxt_flit[0] = mk(2'b00, 8'd0, 22'h100);
        nxt_flit[1] = mk(2'b00, 8'd2, 22'h111);
        drive(4'b0011, 1'b1, 4'b0010);
        chk("lock_head_id", bus.vc_id_o, 64'd1);
        nxt_flit[1] = mk(2'b01, 8'd0, 22'h112);
        drive(4'b0011, 1'b1, 4'b0000);
        chk("lock_body_ready", bus.vc_ready_o, 64'b0010);
        nxt_flit[1] = mk(2'b11, 8'd0, 22'h113);
        drive(4'b0011, 1'b1, 4'b0000);
        chk("lock_tail_data", bus.fdata_o, mk(2'b11, 8'd0, 22'h113));
        drive(4'b0001, 1'b1, 4'b0000);
        chk("after_tail_id", bus.vc_ready_o, 64'b0001);
        drive(4'h0, 1'b1, 4'b0011);
        drive(4'h0, 1'b1, 4'b0010);

        // Credit exhaustion on VC2, then a returned credit takes effect one cycle later.
        nxt_flit[2] = mk(2'b00, 8'd0, 22'h222);
        drive(4'b0100, 1'b1, 4'h0);
        chk("cred_1_id", bus.vc_id_o, 64'd2);
        drive(4'b0100, 1'b1, 4'h0);
        chk("cred_2_valid", bus.valid_o, 64'd1);
        drive(4'b0100, 1'b1, 4'h0);
        chk("cred_held", bus.valid_o, 64'd0);
        drive(4'b0100, 1'b1, 4'b0100);
        chk("cred_same_cycle", bus.valid_o, 64'd0);
        drive(4'b0100, 1'b1, 4'h0);
        chk("cred_resumed", bus.vc_ready_o, 64'b0100);
        drive(4'h0, 1'b1, 4'b0100);
        drive(4'h0, 1'b1, 4'b0100);

        // Backpressure: the grant holds on VC3 and nothing pops.
        nxt_flit[0] = mk(2'b00, 8'd0, 22'h300);
        nxt_flit[3] = mk(2'b00, 8'd0, 22'h333);
        for (int k = 0; k < 5; k++) begin
            drive(4'b1001, 1'b0, 4'h0);
            chk("bp_id", bus.vc_id_o, 64'd3);
            chk("bp_data", bus.fdata_o, mk(2'b00, 8'd0, 22'h333));
            chk("bp_ready", bus.vc_ready_o, 64'd0);
        end
        drive(4'b1000, 1'b1, 4'h0);
        drive(4'b1000, 1'b1, 4'h0);
        chk("bp_cred_kept", bus.vc_ready_o, 64'b1000);
        drive(4'b1000, 1'b1, 4'h0);
        chk("bp_cred_out", bus.valid_o, 64'd0);
        drive(4'h0, 1'b1, 4'b1000);
        drive(4'h0, 1'b1, 4'b1000);

        // Errors: a repeated head on the locked VC, then a credit returned at full credit.
        nxt_flit[0] = mk(2'b00, 8'd1, 22'h400);
        drive(4'b0001, 1'b1, 4'b0001);
        nxt_flit[0] = mk(2'b00, 8'd1, 22'h401);
        drive(4'b0001, 1'b1, 4'b0001);
        chk("err_before", bus.err_o, 64'd0);
        nxt_flit[0] = mk(2'b11, 8'd0, 22'h402);
        drive(4'b0001, 1'b1, 4'b0001);
        chk("err_head", bus.err_o, 64'd1);
        drive(4'h0, 1'b1, 4'b0001);
        chk("err_one_cycle", bus.err_o, 64'd0);
        drive(4'h0, 1'b1, 4'h0);
        chk("err_sat", bus.err_o, 64'd1);
        drive(4'h0, 1'b1, 4'h0);
        chk("err_sat_clear", bus.err_o, 64'd0);
        nxt_flit[0] = mk(2'b00, 8'd0, 22'h403);
        drive(4'b0001, 1'b1, 4'h0);
        drive(4'b0001, 1'b1, 4'h0);
        chk("sat_cred_2nd", bus.valid_o, 64'd1);
        drive(4'b0001, 1'b1, 4'h0);
        chk("sat_cred_3rd", bus.valid_o, 64'd0);

        // Reset mid-packet: lock dropped, VC0 has priority again.
        nxt_flit[1] = mk(2'b00, 8'd3, 22'h500);
        drive(4'b0010, 1'b1, 4'h0);
        nxt_flit[1] = mk(2'b01, 8'd0, 22'h501);
        drive(4'b0010, 1'b1, 4'h0);
        chk("mid_body_id", bus.vc_id_o, 64'd1);
        nxt_arst = 1'b0;
        nxt_flit[0] = mk(2'b00, 8'd0, 22'h510);
        drive(4'b0011, 1'b1, 4'h0);
        chk("mid_rst_outs", {bus.valid_o, bus.vc_ready_o, bus.vc_id_o, bus.fdata_o}, 64'd0);
        nxt_arst = 1'b1;
        drive(4'b0011, 1'b1, 4'h0);
        chk("mid_rel_id", bus.vc_ready_o, 64'b0001);
        drive(4'b0011, 1'b1, 4'h0);
        chk("mid_idle_id", bus.vc_id_o, 64'd1);
        drive(4'b0011, 1'b1, 4'h0);
        chk("mid_rr_id", bus.vc_id_o, 64'd0);
        drive(4'h0, 1'b0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vc_out_arbiter.md
# vc_out_arbiter

Output-port virtual-channel scheduler for the NoC router. Sits between the per-VC input buffers (`vc_buffer` instances, 34-bit flits, 2-bit VC id) and one output link. Each cycle it grants at most one VC and forwards that VC's flit. It enforces wormhole packet locking and tracks per-VC downstream credits.

## Interface
- `N_VC`, 4: number of virtual channels. The VC id width is fixed at 2, so `N_VC` must be ≤ 4.
- `FLIT_W`, 34: flit width. Bits [33:32] are the flit type: 00 head, 01 body, 10 body, 11 tail.
- `SIZE_LSB`, 22 / `SIZE_MSB`, 29: packet-size field of a head flit.
- `CREDITS`, 2: downstream buffer depth per VC, and the reset credit value.

- `clk`  in  1  clock; all state changes on the rising edge.
- `arst`  in  1  reset; asynchronous assert, active-low (0 = reset).
- `vc_fdata_i`  in  N_VC*FLIT_W  packed flits; VC i occupies [i*FLIT_W +: FLIT_W].
- `vc_valid_i`  in  N_VC  VC i has a flit at its buffer head.
- `vc_ready_o`  out  N_VC  pops VC i; high only for the granted VC when `ready_i` is high.
- `fdata_o`  out  FLIT_W  flit forwarded to the link.
- `vc_id_o`  out  2  VC index of `fdata_o`.
- `valid_o`  out  1  `fdata_o` is valid.
- `ready_i`  in  1  link accepts the flit.
- `credit_i`  in  N_VC  one-cycle pulse: downstream freed one slot of VC i.
- `err_o`  out  1  registered one-cycle protocol-error pulse.

## Operation
- **Eligibility.** VC i is eligible when `vc_valid_i[i]` is high and `credit[i] != 0`.
- **States.** The block is in IDLE or LOCKED. It also holds `rr_ptr` (2 bits), `lock_vc` (2 bits), `credit[i]` (width clog2(CREDITS+1)) and `err_o`.
- **IDLE.** Grant the first eligible VC scanning from `rr_ptr+1` upward, modulo `N_VC`.
- **LOCKED.** Only `lock_vc` may be granted, and only when it is eligible. All other VCs stall.
- **Forwarding.** With a grant g: `valid_o`=1, `fdata_o`=flit of g, `vc_id_o`=g. With no grant: `valid_o`=0, `fdata_o`=0, `vc_id_o`=0.
- **Handshake.** A handshake is `valid_o && ready_i`. On a handshake, `vc_ready_o[g]`=1; otherwise all bits are 0.
- **IDLE transitions on a handshake:**
  - `rr_ptr` <= g.
  - A head flit with size field ≠ 0 moves to LOCKED with `lock_vc` <= g.
  - A single-flit head (size 0), body or tail stays in IDLE.
- **LOCKED transitions on a handshake:**
  - A tail flit moves to IDLE. `rr_ptr` <= `lock_vc`.
  - A head flit from `lock_vc` is forwarded, the state stays LOCKED, and `err_o` pulses.
- **Credits:**
  - A handshake on VC i decrements `credit[i]`.
  - `credit_i[i]` increments `credit[i]`.
  - Both in the same cycle leave `credit[i]` unchanged.
  - `credit_i[i]` while `credit[i]`==CREDITS with no handshake on i: the counter saturates and `err_o` pulses.
- **Reset values:** IDLE, `rr_ptr`=N_VC-1 (so VC0 has first priority), `lock_vc`=0, every credit = CREDITS, `err_o`=0. While `arst`=0, force `valid_o`=0, `vc_ready_o`=0, `fdata_o`=0, `vc_id_o`=0.

## Timing
- The forward path is combinational: `vc_valid_i`/`vc_fdata_i` → `valid_o`/`fdata_o`/`vc_id_o`/`vc_ready_o` with zero latency. Throughput is 1 flit per cycle.
- `vc_ready_o` depends combinationally on `ready_i`. The upstream buffer pops on the same edge the link accepts.
- The grant is stable only while `ready_i`=0 and the inputs are held. A held VC keeps its grant in IDLE, because `rr_ptr` updates only on a handshake.
- A credit returned in cycle t makes the VC eligible in cycle t+1.
- `err_o` is high in the cycle after the offending edge, for exactly one cycle.
- Reset mid-packet drops the lock immediately. After deassertion, the first grant is decided in the first cycle; there is no flit replay.
- A tail handshake and a new head on another VC in the same cycle: the other VC is granted no earlier than the next cycle.

## Test plan
- **Reset and first grant.** Hold reset, then release. Drive all 4 VCs valid with single-flit heads (type 00, size 0) and `ready_i`=1. Required: `vc_id_o` sequence 0,1,2,3,0; `vc_ready_o` one-hot each cycle.
- **Wormhole lock.** VC1 sends head (size 2), body, tail, with VC0 continuously valid. Required: `vc_id_o`=1 for 3 consecutive cycles, VC0 stalled throughout, VC0 granted in the cycle after the tail.
- **Credits.** Send 2 flits on VC2 with no `credit_i`. Required: the third flit is held (`valid_o`=0 when VC2 is alone). Pulse `credit_i[2]`; the flit is sent in the next cycle.
- **Backpressure.** With `ready_i`=0 for 5 cycles: `fdata_o`/`vc_id_o` stay stable, `vc_ready_o`=0, credits unchanged.
- **Errors.** A head on the locked VC → `err_o`=1 for one cycle. `credit_i[0]` at full credit → `err_o` pulse, credit stays 2.
- **Reset mid-packet.** Assert `arst` after a head (size 3) and one body. Required: outputs zero immediately; after release, state IDLE, credits 2, VC0 has priority.
